// File: rtl/fpu_pkg.sv
// Shared FPU definitions: fflags bit positions, exponent constants and the
// writeback entry layout used by the float-to-int writeback stage.
package fpu_pkg;

    // fflags bit indices, laid out as {NV,DZ,OF,UF,NX}
    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    // Single-precision exponent bias and the first biased exponent whose
    // magnitude no longer fits a signed 32-bit integer (2^31).
    localparam int EXP_BIAS    = 127;
    localparam int EXP_INT_OVF = 158;

    // Widest destination index an entry can carry; narrower RD_W values are
    // zero-extended into this field.
    localparam int RD_W_MAX = 8;

    typedef struct packed {
        logic [RD_W_MAX-1:0] rd;
        logic [31:0]         data;
        logic [4:0]          flags;
    } cvt_wb_entry_t;

endpackage

// File: rtl/fcvt_w_wb_if.sv
// Converter-result input channel and register-file writeback channel.
//
// Handshake: on both channels a transfer happens on a rising clock edge
// where valid && ready are both 1. A producer holding valid=1 keeps its
// payload stable until the transfer; ready never depends combinationally on
// valid of the same channel.
interface fcvt_w_wb_if #(
    parameter int RD_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [RD_W-1:0] in_rd;
    logic [31:0]     in_src;
    logic [31:0]     in_result;
    logic            wb_valid;
    logic            wb_ready;
    logic [RD_W-1:0] wb_rd;
    logic [31:0]     wb_data;

    // Environment side: drives converter results, consumes writebacks
    modport master (
        output in_valid, in_rd, in_src, in_result, wb_ready,
        input  in_ready, wb_valid, wb_rd, wb_data
    );

    // Stage side
    modport slave (
        input  in_valid, in_rd, in_src, in_result, wb_ready,
        output in_ready, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/fcvt_w_flags.sv
// Combinational RISC-V exception classifier for fcvt.w.s: looks only at the
// source float and reports NV (not representable) or NX (rounded away bits).
module fcvt_w_flags
    import fpu_pkg::*;
(
    input  logic [31:0] src,
    output logic [4:0]  flags
);
    logic        sgn;
    logic [7:0]  exp_b;
    logic [22:0] frac;
    logic [4:0]  frac_sh;
    logic [23:0] frac_mask;
    logic        nv;
    logic        nx;

    assign sgn   = src[31];
    assign exp_b = src[30:23];
    assign frac  = src[22:0];

    // Classify by exponent range; fraction bits below the binary point give NX
    always_comb begin
        nv        = 1'b0;
        nx        = 1'b0;
        frac_sh   = 5'd0;
        frac_mask = 24'd0;
        if (exp_b == 8'hFF) begin
            nv = 1'b1;
        end else if (exp_b >= 8'(EXP_INT_OVF)) begin
            // -2^31 is the only value at this magnitude that still fits
            nv = !(sgn && exp_b == 8'(EXP_INT_OVF) && frac == 23'd0);
        end else if (exp_b < 8'(EXP_BIAS)) begin
            nx = (exp_b != 8'd0) || (frac != 23'd0);
        end else if (exp_b <= 8'd149) begin
            // 150-e fraction bits sit below the binary point (23 at e=127)
            frac_sh   = 5'(8'd150 - exp_b);
            frac_mask = (24'd1 << frac_sh) - 24'd1;
            nx        = |(frac & frac_mask[22:0]);
        end
        flags        = 5'd0;
        flags[FF_NV] = nv;
        flags[FF_NX] = nx;
    end
endmodule

// File: rtl/fcvt_w_wb.sv
// Writeback stage after the float-to-int converter: classifies exception
// flags, buffers results in an in-order FIFO, retires them to the integer
// register file and accumulates retired flags into a sticky fflags CSR.
module fcvt_w_wb
    import fpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int RD_W  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    fcvt_w_wb_if.slave         io,
    input  logic               csr_wr_en,
    input  logic [4:0]         csr_wr_data,
    input  logic               csr_clr,
    output logic [4:0]         fflags
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cvt_wb_entry_t      mem [DEPTH];
    cvt_wb_entry_t      in_entry;
    cvt_wb_entry_t      head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [4:0]         in_flags;
    logic [4:0]         ret_flags;
    logic [4:0]         ff_base;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    fcvt_w_flags u_flags (
        .src   (io.in_src),
        .flags (in_flags)
    );

    // in_ready depends only on occupancy, never on wb_ready
    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign io.in_ready = !full;
    assign io.wb_valid = !empty;
    assign push        = io.in_valid && !full;
    assign pop         = io.wb_ready && !empty;

    // Head entry drives the writeback payload; it only moves on a pop
    assign head        = mem[rd_ptr];
    assign io.wb_rd    = head.rd[RD_W-1:0];
    assign io.wb_data  = head.data;

    // Pack the incoming result with its classified flags
    always_comb begin
        in_entry       = '0;
        in_entry.rd    = RD_W_MAX'(io.in_rd);
        in_entry.data  = io.in_result;
        in_entry.flags = in_flags;
    end

    // Entry storage; cleared on reset so the head payload reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // Pointers wrap naturally; count tracks occupancy 0..DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // CSR write beats clear; the retiring entry's flags are always OR-ed in
    always_comb begin
        ret_flags = pop ? head.flags : 5'd0;
        if (csr_wr_en) begin
            ff_base = csr_wr_data;
        end else if (csr_clr) begin
            ff_base = 5'd0;
        end else begin
            ff_base = fflags;
        end
    end

    // Sticky exception flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fflags <= 5'd0;
        end else begin
            fflags <= ff_base | ret_flags;
        end
    end
endmodule
